// File: rtl/sar_conv_sequencer.sv
// rtl/sar_conv_sequencer.sv - SAR conversion launcher, result tagger and FWFT result FIFO
// Periodic/single-shot cnvst generation, eoc capture with sequence tags, sticky error flags.
module sar_conv_sequencer #(
    parameter int DATA_W     = 10,
    parameter int SEQ_W      = 6,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [CNT_W-1:0]              period,
    input  logic                          trig,
    input  logic                          clr_flags,
    output logic                          cnvst,
    input  logic [DATA_W-1:0]             sar_in,
    input  logic                          eoc_in,
    output logic [SEQ_W+DATA_W-1:0]       dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          overrun,
    output logic                          tick_miss,
    output logic                          timeout_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam int EW = SEQ_W + DATA_W;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_EOC, S_CAPTURE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic                pending_q, pending_d;
    logic [SEQ_W-1:0]    seq_q, seq_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic [EW-1:0]       mem_q [FIFO_DEPTH];
    logic [EW-1:0]       mem_d [FIFO_DEPTH];
    logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]         count_q, count_d;
    logic                ovr_q, ovr_d, miss_q, miss_d, to_q, to_d;
    logic                tick, push, pop, wr_en;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tcnt_d    = tcnt_q;
        pending_d = pending_q;
        seq_d     = seq_q;
        res_d     = res_q;
        mem_d     = mem_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        tick      = 1'b0;
        push      = 1'b0;
        // Sticky flags: clear first so a same-cycle event still sets them.
        ovr_d     = ovr_q  & ~clr_flags;
        miss_d    = miss_q & ~clr_flags;
        to_d      = to_q   & ~clr_flags;

        if (en) begin
            if (cnt_q == '0) begin
                tick  = 1'b1;
                cnt_d = period;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else begin
            cnt_d = period;
        end

        if (tick && pending_q) miss_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (tick || pending_q || (trig && !en)) begin
                    state_d   = S_LAUNCH;
                    pending_d = 1'b0;
                    tcnt_d    = '0;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT_EOC;
                tcnt_d  = tcnt_q + TW'(1);
            end
            S_WAIT_EOC: begin
                if (eoc_in) begin
                    res_d   = sar_in;
                    state_d = S_CAPTURE;
                end else if (tcnt_q == TO_LAST) begin
                    to_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_CAPTURE: begin
                push    = 1'b1;
                seq_d   = seq_q + SEQ_W'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (tick && state_q != S_IDLE) pending_d = 1'b1;

        // A pop frees the slot before the push lands, so full+pop+push is not an overrun.
        pop   = (count_q != '0) && dout_ready;
        wr_en = push && ((count_q != FULL_CNT) || pop);
        if (push && !wr_en) ovr_d = 1'b1;
        if (pop) rd_d = rd_q + AW'(1);
        if (wr_en) begin
            mem_d[wr_q] = {seq_q, res_q};
            wr_d        = wr_q + AW'(1);
        end
        count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= period;
            tcnt_q    <= '0;
            pending_q <= 1'b0;
            seq_q     <= '0;
            res_q     <= '0;
            mem_q     <= '{default: '0};
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            ovr_q     <= 1'b0;
            miss_q    <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tcnt_q    <= tcnt_d;
            pending_q <= pending_d;
            seq_q     <= seq_d;
            res_q     <= res_d;
            mem_q     <= mem_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            count_q   <= count_d;
            ovr_q     <= ovr_d;
            miss_q    <= miss_d;
            to_q      <= to_d;
        end
    end

    assign cnvst       = (state_q == S_LAUNCH);
    assign busy        = (state_q == S_LAUNCH) || (state_q == S_WAIT_EOC);
    assign dout        = mem_q[rd_q];
    assign dout_valid  = (count_q != '0);
    assign fifo_count  = count_q;
    assign overrun     = ovr_q;
    assign tick_miss   = miss_q;
    assign timeout_err = to_q;

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// tb/tb_sar_conv_sequencer.sv - self-checking bench for sar_conv_sequencer
// SAR behavioural model plus a queue-based result model, period table and corner sequences.
module tb_sar_conv_sequencer;

    localparam int DW    = 10;
    localparam int SW    = 6;
    localparam int CW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0, rst = 1'b1, en = 1'b0, trig = 1'b0, clr_flags = 1'b0;
    logic          eoc_in = 1'b0, dout_ready = 1'b0;
    logic [CW-1:0] period = '0;
    logic [DW-1:0] sar_in = '0;
    logic          cnvst, dout_valid, busy, overrun, tick_miss, timeout_err;
    logic [SW+DW-1:0] dout;
    logic [2:0]    fifo_count;

    always #5 clk = ~clk;

    sar_conv_sequencer dut (
        .clk(clk), .rst(rst), .en(en), .period(period), .trig(trig), .clr_flags(clr_flags),
        .cnvst(cnvst), .sar_in(sar_in), .eoc_in(eoc_in), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .fifo_count(fifo_count), .busy(busy), .overrun(overrun),
        .tick_miss(tick_miss), .timeout_err(timeout_err)
    );

    typedef struct {
        int per;
        int lt;
        int gap;
        bit miss_chk;
        bit miss;
    } prow_t;

    int n_chk = 0, n_err = 0, cyc_n = 0;
    int lat = 24, cd = 0, rdy_mode = 0, cap_cnt = 0, eoc_cyc = -1;
    bit sar_en = 1'b1, sar_rand = 1'b0;
    logic [DW-1:0] sar_fix = 10'h2A5;
    logic [DW-1:0] cap_val = '0;
    logic [SW-1:0] m_seq = '0;
    bit m_ovr = 1'b0, live = 1'b0, cap_pend = 1'b0;
    logic [SW+DW-1:0] mq[$];
    int cn_q[$];
    int popped[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc_n);
        end
    endtask

    // One clock: drive SAR/consumer, advance the reference model across the edge, then compare.
    task automatic cyc();
        bit pop;
        eoc_in = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                eoc_in  = 1'b1;
                sar_in  = sar_rand ? DW'($urandom) : sar_fix;
                eoc_cyc = cyc_n;
            end
        end
        if (cnvst && sar_en) cd = lat;
        if (rdy_mode == 2) dout_ready = 1'($urandom_range(0, 1));
        else dout_ready = (rdy_mode == 1);
        chk("cnvst_during_eoc", cnvst & eoc_in, 0);
        if (cnvst) cn_q.push_back(cyc_n);

        if (rst) begin
            mq.delete();
            m_seq = '0; m_ovr = 1'b0; live = 1'b0; cap_pend = 1'b0;
        end else begin
            pop = (mq.size() != 0) && dout_ready;
            if (pop) begin
                popped.push_back(int'(mq[0][SW+DW-1:DW]));
                void'(mq.pop_front());
            end
            if (clr_flags) m_ovr = 1'b0;
            if (cap_pend) begin
                cap_cnt++;
                if (mq.size() < DEPTH) mq.push_back({m_seq, cap_val});
                else m_ovr = 1'b1;
                m_seq++;
            end
            cap_pend = eoc_in && live;
            if (eoc_in) begin
                live    = 1'b0;
                cap_val = sar_in;
            end
            if (cnvst && sar_en) live = 1'b1;
        end

        @(negedge clk);
        cyc_n++;
        chk("fifo_count", fifo_count, mq.size());
        chk("dout_valid", dout_valid, mq.size() != 0);
        if (mq.size() != 0) chk("dout", dout, mq[0]);
        chk("overrun", overrun, m_ovr);
    endtask

    task automatic do_reset();
        en = 1'b0; trig = 1'b0; clr_flags = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cnvst"}, cnvst, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_dout"}, dout, 0);
        chk({tag, "_dout_valid"}, dout_valid, 0);
        chk({tag, "_fifo_count"}, fifo_count, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_tick_miss"}, tick_miss, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    initial begin
        prow_t rows[6];
        int first_v, t0, rc, exp_gap;

        rows[0] = '{40, 24, 41, 1'b1, 1'b0};
        rows[1] = '{30, 24, 31, 1'b1, 1'b0};
        rows[2] = '{26, 24, 27, 1'b1, 1'b0};
        rows[3] = '{5,  24, 27, 1'b1, 1'b1};
        rows[4] = '{0,  10, 13, 1'b0, 1'b0};
        rows[5] = '{0,  24, 27, 1'b0, 1'b0};

        @(negedge clk);
        do_reset();
        chk_reset_outputs("rst");

        // Single shot
        sar_rand = 1'b0; sar_fix = 10'h2A5; lat = 24; rdy_mode = 0;
        cn_q.delete();
        trig = 1'b1; cyc(); trig = 1'b0;
        first_v = -1;
        for (int i = 0; i < 80; i++) begin
            cyc();
            if (dout_valid && first_v < 0) first_v = cyc_n;
        end
        chk("ss_cnvst_count", cn_q.size(), 1);
        chk("ss_eoc_latency", (cn_q.size() > 0) ? eoc_cyc - cn_q[0] : -1, 24);
        chk("ss_dout", dout, {6'd0, 10'h2A5});
        chk("ss_valid_delay", first_v - eoc_cyc, 2);
        chk("ss_busy", busy, 0);
        rdy_mode = 1; cyc(); cyc(); rdy_mode = 0;

        // Periodic table
        for (int r = 0; r < 6; r++) begin
            do_reset();
            period = CW'(rows[r].per); lat = rows[r].lt;
            sar_rand = 1'b1; rdy_mode = 1;
            cn_q.delete(); popped.delete();
            en = 1'b1;
            for (int i = 0; i < 400 && cn_q.size() < 5; i++) cyc();
            en = 1'b0;
            chk("tbl_cnvst_count", cn_q.size() >= 5, 1);
            for (int k = 1; k < cn_q.size() && k < 5; k++)
                chk("tbl_gap", cn_q[k] - cn_q[k-1], rows[r].gap);
            if (rows[r].miss_chk) chk("tbl_tick_miss", tick_miss, rows[r].miss);
            repeat (80) cyc();
            for (int k = 0; k < 4; k++)
                chk("tbl_seq_order", (popped.size() > k) ? popped[k] : -1, k);
        end

        // Overrun with period=0 and a stalled consumer
        do_reset();
        period = '0; lat = 10; rdy_mode = 0; sar_rand = 1'b1;
        cn_q.delete(); popped.delete(); cap_cnt = 0;
        en = 1'b1;
        for (int i = 0; i < 200 && cn_q.size() < 5; i++) cyc();
        en = 1'b0;
        for (int i = 0; i < 200 && cap_cnt < 6; i++) cyc();
        repeat (5) cyc();
        chk("ovr_conv_count", cn_q.size(), 6);
        chk("ovr_fifo_full", fifo_count, 4);
        chk("ovr_flag", overrun, 1);
        rdy_mode = 1; repeat (6) cyc(); rdy_mode = 0;
        for (int k = 0; k < 4; k++)
            chk("ovr_drain_seq", (popped.size() > k) ? popped[k] : -1, k);
        trig = 1'b1; cyc(); trig = 1'b0;
        repeat (40) cyc();
        chk("ovr_next_valid", dout_valid, 1);
        chk("ovr_next_seq", dout[SW+DW-1:DW], 6);

        // Timeout, then recovery
        do_reset();
        sar_en = 1'b0; cn_q.delete();
        trig = 1'b1; cyc(); trig = 1'b0;
        for (int i = 0; i < 10 && cn_q.size() == 0; i++) cyc();
        t0 = (cn_q.size() > 0) ? cn_q[0] : cyc_n;
        chk("to_launched", cn_q.size(), 1);
        while (cyc_n < t0 + 63) cyc();
        chk("to_before", timeout_err, 0);
        chk("to_busy_before", busy, 1);
        cyc();
        chk("to_flag", timeout_err, 1);
        chk("to_idle", busy, 0);
        repeat (5) cyc();
        chk("to_no_write", fifo_count, 0);
        chk("to_no_relaunch", cn_q.size(), 1);
        clr_flags = 1'b1; cyc(); clr_flags = 1'b0;
        chk("to_clr", timeout_err, 0);
        sar_en = 1'b1; sar_rand = 1'b0; sar_fix = 10'h155; lat = 24;
        trig = 1'b1; cyc(); trig = 1'b0;
        repeat (40) cyc();
        chk("to_next_dout", dout, {6'd0, 10'h155});

        // Reset while waiting for eoc
        do_reset();
        lat = 24; sar_rand = 1'b1;
        trig = 1'b1; cyc(); trig = 1'b0;
        repeat (10) cyc();
        chk("mr_busy", busy, 1);
        rc = cyc_n;
        rst = 1'b1; cyc(); rst = 1'b0;
        repeat (40) cyc();
        chk("mr_eoc_seen", eoc_cyc > rc, 1);
        chk_reset_outputs("mr");

        // Randomised periodic runs against the model
        for (int it = 0; it < 8; it++) begin
            do_reset();
            period = CW'($urandom_range(0, 45));
            lat = $urandom_range(1, 50);
            sar_rand = 1'b1; rdy_mode = 2;
            cn_q.delete();
            en = 1'b1;
            for (int i = 0; i < 300; i++) begin
                clr_flags = ($urandom_range(0, 15) == 0);
                trig = 1'($urandom_range(0, 1));
                cyc();
            end
            clr_flags = 1'b0; trig = 1'b0; en = 1'b0;
            exp_gap = (int'(period) + 1 > lat + 3) ? int'(period) + 1 : lat + 3;
            for (int k = 1; k < cn_q.size() && cn_q[k] < cyc_n - 1; k++)
                chk("rnd_gap", cn_q[k] - cn_q[k-1], exp_gap);
            rdy_mode = 1;
            repeat (80) cyc();
            chk("rnd_timeout", timeout_err, 0);
            chk("rnd_drained", fifo_count, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sar_conv_sequencer.md
Name: sar_conv_sequencer

Overview:
- Conversion sequencer and result reader on the digital side of the 10-bit coarse/fine SAR logic.
- Launches conversions: periodic or single-shot `cnvst` pulses.
- Captures `sar` when `eoc` pulses, tags each result with a sequence number, and buffers it in a small FIFO with a valid/ready output stream.
- Detects stalled conversions (timeout) and dropped results or ticks (overrun/miss).

Parameters:
- DATA_W, 10, SAR result width.
- SEQ_W, 6, result sequence-tag width.
- CNT_W, 16, period counter width.
- TIMEOUT, 64, cycles allowed from `cnvst` to `eoc`.
- FIFO_DEPTH, 4, result FIFO entries (power of 2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en  in  1  periodic conversion enable
- period  in  CNT_W  cycles between launch ticks; 0 = back-to-back
- trig  in  1  single-shot request, honoured only when en=0
- clr_flags  in  1  clears the sticky flags
- cnvst  out  1  conversion start pulse to SAR logic
- sar_in  in  DATA_W  SAR digital output
- eoc_in  in  1  SAR end-of-conversion pulse
- dout  out  SEQ_W+DATA_W  {seq, result}
- dout_valid  out  1  FIFO not empty
- dout_ready  in  1  consumer accept
- fifo_count  out  clog2(FIFO_DEPTH)+1  entries held
- busy  out  1  conversion in flight
- overrun  out  1  sticky: result dropped, FIFO full
- tick_miss  out  1  sticky: launch tick lost
- timeout_err  out  1  sticky: eoc not seen within TIMEOUT

Behaviour:
- Reset values: all outputs 0; FIFO empty; seq=0; pending=0; FSM=IDLE; period counter loaded with `period`.
- FSM states: IDLE, LAUNCH, WAIT_EOC, CAPTURE.
- IDLE:
  - Leaves when a launch is pending: tick, pending flag, or `trig` with en=0.
  - Next state LAUNCH.
- LAUNCH:
  - `cnvst`=1 for exactly this one cycle.
  - Timeout counter cleared; `busy`=1.
  - Next state WAIT_EOC.
- WAIT_EOC:
  - `eoc_in`=1 → latch `sar_in` (valid in the eoc cycle) → CAPTURE.
  - Timeout counter reaches TIMEOUT-1 with no eoc → `timeout_err`=1, nothing written, seq unchanged → IDLE.
  - `eoc_in` outside WAIT_EOC is ignored.
- CAPTURE:
  - Write {seq, latched result} into the FIFO if not full, then seq increments mod 2^SEQ_W.
  - If the FIFO is full: drop the new result, set `overrun`=1, seq still increments so the consumer sees a gap.
  - `busy`=0; next state IDLE.
- `cnvst` never asserts during the cycle `eoc_in` is high. The minimum spacing is eoc → CAPTURE → IDLE → LAUNCH, so at period=0 the next `cnvst` comes 3 cycles after eoc.
- Period counter:
  - Counts down while en=1.
  - At 0 it produces a tick and reloads `period`.
  - period=0: tick every cycle, so conversions run back-to-back.
  - en=0: counter is held at `period`; no ticks.
  - A change to `period` takes effect at the next reload.
- Tick while busy (state≠IDLE): sets pending.
- Tick while pending is already set: `tick_miss`=1. At period=0 this is expected, and the bench ignores `tick_miss` in that mode.
- `trig` while en=1 or busy: ignored.
- FIFO:
  - Synchronous, first-word fall-through; `dout` is the head entry; `dout_valid` = (count≠0).
  - Pop on dout_valid & dout_ready.
  - Simultaneous push and pop when full: pop first, push accepted, no overrun.
  - Simultaneous push and pop when empty: push only.
- `clr_flags`:
  - Clears all three sticky flags.
  - If a flag event occurs in the same cycle, the set wins.
- Reset mid-conversion: abandons it immediately and flushes the FIFO. A later `eoc_in` is ignored because the FSM is in IDLE.

Test Plan:
- Single shot:
  - Stimulus: en=0, trig pulse; bench SAR model returns `eoc_in` 24 cycles after `cnvst` with sar_in=10'h2A5.
  - Required: exactly one `cnvst` pulse; dout={6'd0, 10'h2A5}; dout_valid 2 cycles after eoc; busy low afterwards.
- Periodic:
  - Stimulus: en=1, period=40, dout_ready=1, eoc latency 24.
  - Required: `cnvst` every 41 cycles; seq 0,1,2,3 in order; tick_miss=0.
- Overrun:
  - Stimulus: period=0, dout_ready=0, 6 conversions.
  - Required: fifo_count saturates at 4; overrun=1; after draining, dout seq = 0,1,2,3; the next accepted result carries seq=6.
- Timeout:
  - Stimulus: trig with the bench suppressing eoc.
  - Required: timeout_err=1 at 64 cycles after `cnvst`; no FIFO write; FSM back in IDLE.
  - Then: clr_flags clears timeout_err; a following trig converts normally with seq=0.
- Tick miss:
  - Stimulus: period=5, eoc latency 24.
  - Required: tick_miss=1; each new `cnvst` issues 2 cycles after the prior CAPTURE.
- Mid-conversion reset:
  - Stimulus: rst asserted in WAIT_EOC, then eoc arrives.
  - Required: no capture; all outputs at reset values.
